// File: rtl/fp16_pkg.sv
// FP16 field layout and helpers shared by the arbiter, its interface and the
// Mitchell multiplier core.
package fp16_pkg;

  localparam int FP16_W  = 16;
  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  typedef logic [FP16_W-1:0] fp16_t;

  function automatic logic fp_sign(fp16_t x);
    return x[FP16_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(fp16_t x);
    return x[MAN_W +: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(fp16_t x);
    return x[MAN_W-1:0];
  endfunction

  function automatic fp16_t fp_zero(logic s);
    return {s, {(FP16_W-1){1'b0}}};
  endfunction

  function automatic fp16_t fp_inf(logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// Requester/response bundle of the shared FP16 multiplier. The arbiter sits on
// the slave side; requesters and the result consumer sit on the master side.
interface fp16_mul_arbiter_if
  import fp16_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [FP16_W*N_REQ-1:0] req_a;
  logic [FP16_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [FP16_W-1:0]       rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic                    busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/fp16_mitchell_mul.sv
// LAT-stage FP16 Mitchell multiplier. Stage 1 does all arithmetic; later
// stages only delay data, requester ID and valid so they stay aligned.
module fp16_mitchell_mul
  import fp16_pkg::*;
#(
  parameter int ID_W = 2,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  fp16_t           in_a,
  input  fp16_t           in_b,
  input  logic [ID_W-1:0] in_id,
  output logic [LAT-1:0]  stage_valid,
  output logic            out_valid,
  output fp16_t           out_data,
  output logic [ID_W-1:0] out_id
);

  logic [LAT-1:0]  valid_q;
  fp16_t           data_q [LAT];
  logic [ID_W-1:0] id_q   [LAT];

  logic             sign;
  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic [MAN_W:0]   msum;
  logic [EXP_W+1:0] e_raw;
  logic             underflow;
  logic             overflow;
  fp16_t            product;

  // Mitchell product: add mantissas, fold the carry into the exponent.
  always_comb begin
    sign  = fp_sign(in_a) ^ fp_sign(in_b);
    ea    = fp_exp(in_a);
    eb    = fp_exp(in_b);
    msum  = {1'b0, fp_man(in_a)} + {1'b0, fp_man(in_b)};
    // Seven bits hold -15..48 without wrap; bit 6 is the sign.
    e_raw = {2'b00, ea} + {2'b00, eb} + {{(EXP_W+1){1'b0}}, msum[MAN_W]}
            - (EXP_W+2)'(BIAS);
    underflow = (ea == '0) || (eb == '0) || e_raw[EXP_W+1] || (e_raw == '0);
    overflow  = (ea == EXP_W'(EXP_MAX)) || (eb == EXP_W'(EXP_MAX))
                || (e_raw >= (EXP_W+2)'(EXP_MAX));
    // NOTE: every combinational output gets a value on every path (zero rule
    // first, so it also wins over infinity); a missed path would infer a latch.
    if (underflow)     product = fp_zero(sign);
    else if (overflow) product = fp_inf(sign);
    else               product = {sign, e_raw[EXP_W-1:0], msum[MAN_W-1:0]};
  end

  // Valid bits are the only state that reset must clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the previous
      // stage's old value, which is what turns this loop into a shift register.
      valid_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Payload registers; contents are ignored wherever the matching valid is low.
  always_ff @(posedge clk) begin
    data_q[0] <= product;
    id_q[0]   <= in_id;
    for (int i = 1; i < LAT; i++) begin
      data_q[i] <= data_q[i-1];
      id_q[i]   <= id_q[i-1];
    end
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[LAT-1];
  assign out_data    = data_q[LAT-1];
  assign out_id      = id_q[LAT-1];

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP16 Mitchell multiplier between
// N_REQ requesters, returning ID-tagged results through a credit-protected FIFO.
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  fp16_mul_arbiter_if.slave  bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             accept;
  logic             issue_ok;
  int               idx;

  logic [LAT-1:0]   stage_valid;
  logic             core_valid;
  fp16_t            core_data;
  logic [ID_W-1:0]  core_id;
  logic [CNT_W-1:0] inflight;

  fp16_t            mem_data [DEPTH];
  logic [ID_W-1:0]  mem_id   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;

  // Count occupied core stages; LAT < DEPTH so the sum fits CNT_W bits.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CNT_W'(stage_valid[i]);
  end

  // A free credit exists when FIFO entries plus in-flight work stay below DEPTH.
  assign issue_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C;

  // Round-robin search from ptr upward; the grant is masked without a credit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (grant == '0 && bus.req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
    if (!issue_ok || rst) grant = '0;
  end

  assign bus.req_ready = grant;
  assign accept        = |grant;

  // Advance the pointer past the requester just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= '0;
    else if (accept) ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  fp16_mitchell_mul #(
    .ID_W (ID_W),
    .LAT  (LAT)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (accept),
    .in_a        (bus.req_a[FP16_W*grant_idx +: FP16_W]),
    .in_b        (bus.req_b[FP16_W*grant_idx +: FP16_W]),
    .in_id       (grant_idx),
    .stage_valid (stage_valid),
    .out_valid   (core_valid),
    .out_data    (core_data),
    .out_id      (core_id)
  );

  assign push = core_valid;
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  // FIFO pointers and occupancy; credits guarantee push never hits a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the outputs below are masked while
  // the FIFO is empty, so stale entries can never be observed.
  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= core_data;
      mem_id[wr_ptr]   <= core_id;
    end
  end

  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_data  = bus.rsp_valid ? mem_data[rd_ptr] : '0;
  assign bus.rsp_id    = bus.rsp_valid ? mem_id[rd_ptr]   : '0;
  assign bus.busy      = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter: products, boundary values, round-robin
// fairness, backpressure with credit limit, and reset in mid-operation.
module tb_fp16_mul_arbiter;

  localparam int N_REQ = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_ptr = 0;

  always #5 clk = ~clk;

  fp16_mul_arbiter_if #(.N_REQ(N_REQ)) bus ();

  fp16_mul_arbiter #(
    .N_REQ (N_REQ),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
  endtask

  // Requester i's operand; times 1.0 (0x3C00) the product equals it exactly.
  function automatic logic [15:0] op_of(input int i);
    return 16'h3C00 + 16'(i * 16'h0401);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int i);
    logic [N_REQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Reference round-robin choice: first valid requester at or above ptr.
  function automatic int next_grant(input int ptr, input logic [N_REQ-1:0] valid);
    for (int off = 0; off < N_REQ; off++)
      if (valid[(ptr + off) % N_REQ]) return (ptr + off) % N_REQ;
    return -1;
  endfunction

  task automatic test_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0000", bus.rsp_data); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    rst = 1'b0;
    bus.req_valid = '0;
    step();
  endtask

  // One request from requester idx, checked for grant, latency, data and tag.
  task automatic do_single(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp, input string name);
    int cyc;
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    set_op(idx, a, b);
    bus.req_valid[idx] = 1'b1;
    #1;
    checks++; if (bus.req_ready !== onehot(idx)) begin errors++; $display("FAIL %s_grant: got %b want %b", name, bus.req_ready, onehot(idx)); end
    step();
    bus.req_valid = '0;
    exp_ptr = (idx + 1) % N_REQ;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 10) begin
      step();
      cyc++;
    end
    checks++; if (cyc != LAT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, LAT); end
    checks++; if (bus.rsp_data !== exp) begin errors++; $display("FAIL %s_data: got %h want %h", name, bus.rsp_data, exp); end
    checks++; if (bus.rsp_id !== 2'(idx)) begin errors++; $display("FAIL %s_id: got %0d want %0d", name, bus.rsp_id, idx); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_idle: got busy=%b valid=%b want 0 0", name, bus.busy, bus.rsp_valid); end
  endtask

  task automatic test_products();
    do_single(2, 16'h3E00, 16'h3E00, 16'h4000, "basic_1p5sq");
    do_single(1, 16'h4000, 16'hC200, 16'hC600, "exact_sign");
  endtask

  task automatic test_boundaries();
    do_single(0, 16'h0400, 16'h0400, 16'h0000, "underflow");
    do_single(3, 16'h7800, 16'h7800, 16'h7C00, "overflow_inf");
    do_single(1, 16'h0000, 16'h3C00, 16'h0000, "zero_operand");
  endtask

  task automatic test_fairness();
    int exp_q[$];
    int got;
    int id;
    got = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_op(i, op_of(i), 16'h3C00);
    bus.req_valid = '1;
    for (int n = 0; n < 16; n++) begin
      if (n == 8) bus.req_valid = '0;
      #1;
      if (n < 8) begin
        id = (exp_ptr + n) % N_REQ;
        checks++; if (bus.req_ready !== onehot(id)) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", n, bus.req_ready, onehot(id)); end
        exp_q.push_back(id);
      end else begin
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL fair_idle_grant%0d: got %b want 0000", n, bus.req_ready); end
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL fair_extra_rsp: got id %0d want none", bus.rsp_id);
        end else begin
          id = exp_q.pop_front();
          got++;
          checks++; if (bus.rsp_id !== 2'(id)) begin errors++; $display("FAIL fair_rsp_id: got %0d want %0d", bus.rsp_id, id); end
          checks++; if (bus.rsp_data !== op_of(id)) begin errors++; $display("FAIL fair_rsp_data: got %h want %h", bus.rsp_data, op_of(id)); end
        end
      end
      step();
    end
    checks++; if (got != 8) begin errors++; $display("FAIL fair_rsp_count: got %0d want 8", got); end
  endtask

  task automatic test_backpressure();
    int exp_q[$];
    int got;
    int id;
    logic        have_head;
    logic [15:0] head_data;
    logic [1:0]  head_id;
    got = 0;
    have_head = 1'b0;
    head_data = '0;
    head_id = '0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    for (int n = 0; n < 8; n++) begin
      #1;
      id = (n < DEPTH) ? (exp_ptr + n) % N_REQ : -1;
      checks++; if (bus.req_ready !== onehot(id)) begin errors++; $display("FAIL bp_grant%0d: got %b want %b", n, bus.req_ready, onehot(id)); end
      if (id >= 0) exp_q.push_back(id);
      if (bus.rsp_valid && !have_head) begin
        have_head = 1'b1;
        head_data = bus.rsp_data;
        head_id = bus.rsp_id;
        checks++; if (head_id !== 2'(exp_ptr)) begin errors++; $display("FAIL bp_head_id: got %0d want %0d", head_id, exp_ptr); end
      end else if (bus.rsp_valid) begin
        checks++; if (bus.rsp_data !== head_data || bus.rsp_id !== head_id) begin errors++; $display("FAIL bp_hold: got %h/%0d want %h/%0d", bus.rsp_data, bus.rsp_id, head_data, head_id); end
      end
      step();
    end
    bus.req_valid = '0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL bp_full_state: got valid=%b busy=%b want 1 1", bus.rsp_valid, bus.busy); end
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL bp_extra_rsp: got id %0d want none", bus.rsp_id);
        end else begin
          id = exp_q.pop_front();
          got++;
          checks++; if (bus.rsp_id !== 2'(id) || bus.rsp_data !== op_of(id)) begin errors++; $display("FAIL bp_drain: got %h/%0d want %h/%0d", bus.rsp_data, bus.rsp_id, op_of(id), id); end
        end
      end
      step();
    end
    checks++; if (got != DEPTH) begin errors++; $display("FAIL bp_drain_count: got %0d want %0d", got, DEPTH); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int id;
    int got;
    logic [N_REQ-1:0] valid;
    got = 0;
    valid = 4'b1110;
    bus.rsp_ready = 1'b0;
    bus.req_valid = valid;
    for (int n = 0; n < 4; n++) begin
      #1;
      id = next_grant(exp_ptr, valid);
      checks++; if (bus.req_ready !== onehot(id)) begin errors++; $display("FAIL mid_grant%0d: got %b want %b", n, bus.req_ready, onehot(id)); end
      exp_ptr = (id + 1) % N_REQ;
      step();
    end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_loaded: got valid=%b busy=%b want 1 1", bus.rsp_valid, bus.busy); end
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0000", bus.req_ready); end
    step();
    rst = 1'b0;
    exp_ptr = 0;
    for (int i = 0; i < N_REQ; i++) set_op(i, op_of(i), 16'h3C00);
    #1;
    checks++; if (bus.req_ready !== onehot(0)) begin errors++; $display("FAIL mid_ptr_zero: got %b want %b", bus.req_ready, onehot(0)); end
    bus.rsp_ready = 1'b1;
    step();
    bus.req_valid = '0;
    exp_ptr = 1;
    for (int n = 0; n < 8; n++) begin
      if (bus.rsp_valid) begin
        got++;
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== op_of(0)) begin errors++; $display("FAIL mid_fresh_rsp: got %h/%0d want %h/0", bus.rsp_data, bus.rsp_id, op_of(0)); end
      end
      step();
    end
    checks++; if (got != 1) begin errors++; $display("FAIL mid_rsp_count: got %0d want 1", got); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_products();
    test_boundaries();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp16_mul_arbiter.md
# fp16_mul_arbiter

Round-robin arbiter and sequencer that shares one pipelined FP16 logarithmic (Mitchell-approximation) multiplier between N_REQ requesters. Each requester presents a pair of FP16 operands with a valid/ready handshake. The block grants one request per cycle, tracks the requester ID through the multiplier pipeline, and returns tagged results through a credit-protected output FIFO with backpressure. It sits between the byte-serial I/O front end and the multiply datapath, replacing the single-user fixed sequence.

## Interface
- N_REQ, 4: number of requesters, from 2 to 8.
- LAT, 2: multiplier core pipeline depth in registers, at least 1.
- DEPTH, 4: output FIFO entries, at least LAT+1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  16*N_REQ  operand A per requester; slice i is [16*i +: 16].
- req_b  in  16*N_REQ  operand B per requester.
- req_ready  out  N_REQ  one-hot (or zero) grant/accept.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  16  FP16 product.
- rsp_id  out  $clog2(N_REQ)  requester index for rsp_data.
- busy  out  1  any entry is in flight or in the FIFO.

## Operation
- Credits: credits = DEPTH − fifo_count − inflight.
  - inflight counts valid bits in the core pipeline.
  - Issue is allowed only when credits > 0, so the FIFO can never overflow.
- Arbitration:
  - Search req_valid starting at ptr and scan upward modulo N_REQ.
  - The first asserted requester gets req_ready = 1, and only if issue is allowed.
  - req_ready is combinational from req_valid, ptr and credits.
  - Accept occurs when req_valid[i] and req_ready[i] are both high.
  - On accept, ptr becomes (i+1) mod N_REQ. With no accept, ptr holds.
- Core arithmetic, on fields S[15], E[14:10] and M[9:0]:
  - Sign: S = Sa ^ Sb.
  - msum = Ma + Mb, 11 bits; c = msum[10]; Mout = msum[9:0].
  - e = Ea + Eb − 15 + c, evaluated 7-bit signed.
  - If Ea == 0 or Eb == 0, or e ≤ 0: result {S, 15'h0}. Subnormals are flushed to zero.
  - If Ea == 31 or Eb == 31, or e ≥ 31: result {S, 5'h1F, 10'h0}, i.e. infinity. NaN is not propagated.
  - Otherwise the result is {S, e[4:0], Mout}.
  - The zero rule takes priority over the infinity rule.
- ID tag and valid bit travel alongside the data through every core stage.
- FIFO:
  - The push comes from the core output stage.
  - A pop occurs when rsp_valid and rsp_ready are both high.
  - rsp_data and rsp_id are the FIFO head.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - Pop on empty cannot occur, because rsp_valid is 0.
- Reset:
  - rst high clears ptr, the FIFO pointers and count, and all core valid bits.
  - In-flight work is discarded, including when reset arrives mid-operation.
  - Reset values: rsp_valid 0, rsp_data 0, rsp_id 0, busy 0.
  - req_ready is forced to 0 while rst is high.

## Timing
- Accept at edge k pushes the result into the FIFO at edge k+LAT.
- If the FIFO was empty, rsp_valid rises in the cycle after edge k+LAT. Minimum latency is LAT cycles.
- Throughput is one accept per cycle while credits > 0 and rsp_ready is held high.
- A pop at edge k frees a credit visible in cycle k+1. There is no same-cycle credit bypass.
- Results return in accept order; there is no reordering.
- rsp_data and rsp_id stay stable while rsp_valid is high and rsp_ready is low.
- busy is registered-state derived: (inflight ≠ 0) or (fifo_count ≠ 0).

## Structure
- Package fp16_pkg holds:
  - FP16_W = 16, EXP_W = 5, MAN_W = 10, BIAS = 15, EXP_MAX = 31;
  - field-extract helpers.
- Sub-module fp16_mitchell_mul: LAT-stage core carrying data, ID and valid through its pipeline. The arithmetic is done in stage 1; the remaining stages are pure registers.
- Top level: round-robin pointer, credit counter, DEPTH-entry register FIFO.

## Test plan
- Basic product: N_REQ=4; req 2 sends 0x3E00 × 0x3E00 (1.5 × 1.5) → after LAT cycles rsp_data = 0x4000, rsp_id = 2.
- Exact case and sign: 0x4000 × 0xC200 → 0xC600 (−6.0).
- Boundary cases:
  - 0x0400 × 0x0400 → 0x0000 (underflow flush).
  - 0x7800 × 0x7800 → 0x7C00 (infinity).
  - 0x0000 × 0x3C00 → 0x0000.
- Fairness: all four req_valid held high, rsp_ready = 1 → accepts rotate 0, 1, 2, 3, 0, …, one per cycle; rsp_id sequence matches.
- Backpressure: rsp_ready = 0 and requests continuous → exactly DEPTH accepts, then req_ready = 0. Releasing rsp_ready drains in order with no loss or duplication.
- Reset mid-operation: assert rst with 2 in flight and 2 in the FIFO → rsp_valid, busy and req_ready drop immediately. After release, ptr = 0 and no stale result appears.
